// File: rtl/mover_izquierda_serial_pkg.sv
// Shared ALU constants and the serial left shifter state type.
// Holds the width defaults and the IDLE/SHIFT/DONE encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 10;
    localparam int ALU_SHW   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/mover_izquierda_serial.sv
// Multi-cycle logical left shifter: one bit position per clock.
// Ports: clk, rst_n, start, SUM_REST (operand), shiftL (amount),
//        IZQUIERDA (result), ACARREO (last bit out), busy, done.
module mover_izquierda_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] SUM_REST,
    input  logic [SHW-1:0]   shiftL,
    output logic [WIDTH-1:0] IZQUIERDA,
    output logic             ACARREO,
    output logic             busy,
    output logic             done
);

    shift_state_t     r_state;
    logic [WIDTH-1:0] r_sh;
    logic [SHW-1:0]   r_cnt;
    logic             r_cout;
    logic [WIDTH-1:0] r_izq;
    logic             r_acarreo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sh      <= '0;
            r_cnt     <= '0;
            r_cout    <= 1'b0;
            r_izq     <= '0;
            r_acarreo <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh    <= SUM_REST;
                        r_cnt   <= shiftL;
                        r_cout  <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        // amounts >= WIDTH keep shifting zeros in;
                        // carry then tracks whatever leaves last
                        r_sh   <= {r_sh[WIDTH-2:0], 1'b0};
                        r_cout <= r_sh[WIDTH-1];
                        r_cnt  <= r_cnt - SHW'(1);
                    end else begin
                        r_izq     <= r_sh;
                        r_acarreo <= r_cout;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign IZQUIERDA = r_izq;
    assign ACARREO   = r_acarreo;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_mover_izquierda_serial.sv
// Directed bench for the serial left shifter.
// Latency is counted in negedges after the start edge (done at n+2).
module tb_mover_izquierda_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] SUM_REST;
    logic [3:0] shiftL;
    logic [9:0] IZQUIERDA;
    logic       ACARREO;
    logic       busy;
    logic       done;

    int errors;
    int checks;

    mover_izquierda_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .SUM_REST  (SUM_REST),
        .shiftL    (shiftL),
        .IZQUIERDA (IZQUIERDA),
        .ACARREO   (ACARREO),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and measure when done appears.
    // lat stays 0 when done never shows within the budget.
    task automatic run_op(input logic [9:0] v, input logic [3:0] n,
                          output int lat, output logic b1);
        @(negedge clk);
        SUM_REST = v;
        shiftL   = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        SUM_REST = ~v;
        shiftL   = ~n;
        lat = 0;
        b1  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        SUM_REST = '0;
        shiftL = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (IZQUIERDA !== 10'h000) begin
            errors++;
            $display("FAIL reset_izq got=%h exp=000", IZQUIERDA);
        end
        checks++;
        if (ACARREO !== 1'b0) begin
            errors++;
            $display("FAIL reset_acarreo got=%b exp=0", ACARREO);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
    endtask

    task automatic test_shift(input string nm, input logic [9:0] v,
                              input logic [3:0] n, input logic [9:0] ex,
                              input logic exc, input int exlat);
        int   lat;
        logic b1;
        run_op(v, n, lat, b1);
        checks++;
        if (b1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy got=%b exp=1", nm, b1);
        end
        checks++;
        if (lat != exlat) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exlat);
        end
        checks++;
        if (IZQUIERDA !== ex) begin
            errors++;
            $display("FAIL %s_izq got=%h exp=%h", nm, IZQUIERDA, ex);
        end
        checks++;
        if (ACARREO !== exc) begin
            errors++;
            $display("FAIL %s_acarreo got=%b exp=%b", nm, ACARREO, exc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got=%b%b exp=00", nm, busy, done);
        end
    endtask

    task automatic test_ignored_start();
        int ndone;
        int first;
        @(negedge clk);
        SUM_REST = 10'h001;
        shiftL   = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (IZQUIERDA !== 10'h000) begin
                    errors++;
                    $display("FAIL hold_izq got=%h exp=000", IZQUIERDA);
                end
                SUM_REST = 10'h3FF;
                shiftL   = 4'd9;
                start    = 1'b1;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignored_ndone got=%0d exp=1", ndone);
        end
        checks++;
        if (first != 6) begin
            errors++;
            $display("FAIL ignored_latency got=%0d exp=6", first);
        end
        checks++;
        if (IZQUIERDA !== 10'h010) begin
            errors++;
            $display("FAIL ignored_izq got=%h exp=010", IZQUIERDA);
        end
        checks++;
        if (ACARREO !== 1'b0) begin
            errors++;
            $display("FAIL ignored_acarreo got=%b exp=0", ACARREO);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic b1;
        run_op(10'h0C1, 4'd2, lat, b1);
        checks++;
        if (IZQUIERDA !== 10'h304 || lat != 4) begin
            errors++;
            $display("FAIL b2b_first got=%h/%0d exp=304/4", IZQUIERDA, lat);
        end
        run_op(10'h281, 4'd1, lat, b1);
        checks++;
        if (IZQUIERDA !== 10'h102 || ACARREO !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL b2b_second got=%h/%b/%0d exp=102/1/3",
                     IZQUIERDA, ACARREO, lat);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        SUM_REST = 10'h0FF;
        shiftL   = 4'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (IZQUIERDA !== 10'h000 || ACARREO !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got=%h/%b/%b exp=000/0/0",
                     IZQUIERDA, ACARREO, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL rstmid_nodone got=%0d exp=0", ndone);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_shift("n3", 10'h005, 4'd3, 10'h028, 1'b0, 5);
        test_shift("n1", 10'h3FF, 4'd1, 10'h3FE, 1'b1, 3);
        test_shift("n0", 10'h2AA, 4'd0, 10'h2AA, 1'b0, 2);
        test_shift("n10", 10'h201, 4'd10, 10'h000, 1'b1, 12);
        test_shift("n15", 10'h201, 4'd15, 10'h000, 1'b0, 17);
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
